// File: rtl/batrider_snd_cmd.sv
// rtl/batrider_snd_cmd.sv - 68k-side sound command mailbox: command latches, SND_CS pulse,
// bus hold until the Z80 clears NMI or a timeout expires, and reply/status readback.
module batrider_snd_cmd #(
  parameter int          CS_W    = 4,
  parameter logic [19:0] TIMEOUT = 20'd786432
) (
  input  logic       CLK96,
  input  logic       RESET96,
  input  logic       CPU_STB,
  input  logic       CPU_RNW,
  input  logic [1:0] CPU_A,
  input  logic [7:0] CPU_DIN,
  output logic [7:0] CPU_DOUT,
  output logic       CPU_DTACK,
  output logic [7:0] SOUNDLATCH,
  output logic [7:0] SOUNDLATCH2,
  output logic       SND_CS,
  input  logic       SND_WAIT,
  input  logic [7:0] SOUNDLATCH3,
  input  logic [7:0] SOUNDLATCH4,
  input  logic       SNDIRQ,
  output logic       BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD, S_ACK} state_t;

  localparam logic [3:0]  CS_LAST = 4'(CS_W - 1);
  localparam logic [19:0] TO_LAST = TIMEOUT - 20'd1;

  state_t      state_q, state_d;
  logic [7:0]  latch1_q, latch1_d;
  logic [7:0]  latch2_q, latch2_d;
  logic [7:0]  dout_q, dout_d;
  logic        snd_cs_q, snd_cs_d;
  logic        dtack_q, dtack_d;
  logic        busy_q, busy_d;
  logic        reply_q, reply_d;
  logic        timeout_q, timeout_d;
  logic        seen_wait_q, seen_wait_d;
  logic        sndirq_prev_q, sndirq_prev_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;
  logic [19:0] to_cnt_q, to_cnt_d;
  logic        reply_clr;

  always_comb begin
    state_d       = state_q;
    latch1_d      = latch1_q;
    latch2_d      = latch2_q;
    dout_d        = dout_q;
    snd_cs_d      = snd_cs_q;
    dtack_d       = dtack_q;
    busy_d        = busy_q;
    timeout_d     = timeout_q;
    seen_wait_d   = seen_wait_q;
    pulse_cnt_d   = pulse_cnt_q;
    to_cnt_d      = to_cnt_q;
    sndirq_prev_d = SNDIRQ;
    reply_clr     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (CPU_STB) begin
          busy_d = 1'b1;
          if (!CPU_RNW && !CPU_A[1]) begin
            if (CPU_A[0]) latch2_d = CPU_DIN;
            else          latch1_d = CPU_DIN;
            state_d     = S_PULSE;
            snd_cs_d    = 1'b1;
            pulse_cnt_d = 4'd0;
            to_cnt_d    = 20'd0;
            seen_wait_d = 1'b0;
          end else begin
            state_d = S_ACK;
            dtack_d = 1'b1;
            if (CPU_RNW) begin
              unique case (CPU_A)
                2'd0: begin
                  dout_d    = SOUNDLATCH3;
                  reply_clr = 1'b1;
                end
                2'd1:    dout_d = SOUNDLATCH4;
                2'd2:    dout_d = {5'b0, timeout_q, reply_q, busy_q};
                default: dout_d = 8'hFF;
              endcase
            end else if (CPU_A == 2'd2) begin
              if (CPU_DIN[0]) reply_clr = 1'b1;
              if (CPU_DIN[1]) timeout_d = 1'b0;
            end
          end
        end
      end
      S_PULSE: begin
        if (SND_WAIT) seen_wait_d = 1'b1;
        if (pulse_cnt_q == CS_LAST) begin
          state_d  = S_HOLD;
          snd_cs_d = 1'b0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (SND_WAIT) seen_wait_d = 1'b1;
        to_cnt_d = to_cnt_q + 20'd1;
        // A completed handshake wins over a timeout landing in the same cycle.
        if (seen_wait_q && !SND_WAIT) begin
          state_d = S_ACK;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = S_ACK;
          timeout_d = 1'b1;
        end
      end
      default: begin
        // Writes arrive here with dtack low and spend one extra cycle before acknowledging.
        if (dtack_q) begin
          dtack_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          dtack_d = 1'b1;
        end
      end
    endcase

    reply_d = (reply_q & ~reply_clr) | (SNDIRQ & ~sndirq_prev_q);
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q       <= S_IDLE;
      latch1_q      <= 8'h00;
      latch2_q      <= 8'h00;
      dout_q        <= 8'hFF;
      snd_cs_q      <= 1'b0;
      dtack_q       <= 1'b0;
      busy_q        <= 1'b0;
      reply_q       <= 1'b0;
      timeout_q     <= 1'b0;
      seen_wait_q   <= 1'b0;
      sndirq_prev_q <= 1'b0;
      pulse_cnt_q   <= 4'd0;
      to_cnt_q      <= 20'd0;
    end else begin
      state_q       <= state_d;
      latch1_q      <= latch1_d;
      latch2_q      <= latch2_d;
      dout_q        <= dout_d;
      snd_cs_q      <= snd_cs_d;
      dtack_q       <= dtack_d;
      busy_q        <= busy_d;
      reply_q       <= reply_d;
      timeout_q     <= timeout_d;
      seen_wait_q   <= seen_wait_d;
      sndirq_prev_q <= sndirq_prev_d;
      pulse_cnt_q   <= pulse_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign CPU_DOUT    = dout_q;
  assign CPU_DTACK   = dtack_q;
  assign SOUNDLATCH  = latch1_q;
  assign SOUNDLATCH2 = latch2_q;
  assign SND_CS      = snd_cs_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_batrider_snd_cmd.sv
// tb/tb_batrider_snd_cmd.sv - directed bench with a DTACK scoreboard and a Z80 WAIT model.
module tb_batrider_snd_cmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       rnw = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dtack;
  logic [7:0] sl1, sl2;
  logic       snd_cs;
  logic       snd_wait = 1'b0;
  logic [7:0] sl3 = 8'h00;
  logic [7:0] sl4 = 8'h00;
  logic       sndirq = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    bit         chk_data;
    logic [7:0] data;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  bit model_en = 1'b0;
  bit cs_prev  = 1'b0;
  int rise_cyc = -1000;

  batrider_snd_cmd #(.CS_W(4), .TIMEOUT(20'd100)) dut (
    .CLK96(clk), .RESET96(rst), .CPU_STB(stb), .CPU_RNW(rnw), .CPU_A(addr),
    .CPU_DIN(din), .CPU_DOUT(dout), .CPU_DTACK(dtack), .SOUNDLATCH(sl1),
    .SOUNDLATCH2(sl2), .SND_CS(snd_cs), .SND_WAIT(snd_wait), .SOUNDLATCH3(sl3),
    .SOUNDLATCH4(sl4), .SNDIRQ(sndirq), .BUSY(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Z80 side: WAIT goes high 2 cycles after the SND_CS rising edge and stays up for 50 cycles.
  always @(negedge clk) begin
    if (model_en && snd_cs && !cs_prev) rise_cyc = cyc;
    cs_prev  = snd_cs;
    snd_wait = model_en && (cyc >= rise_cyc + 2) && (cyc < rise_cyc + 52);
  end

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every DTACK must match the oldest pending expectation, in cycle and (for reads) data.
  always @(negedge clk) begin
    if (dtack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dtack", 20'(cyc), 20'hFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_dtack_cyc"}, 20'(cyc), 20'(e.cyc));
        if (e.chk_data) check({e.tag, "_dout"}, {12'h0, dout}, {12'h0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic r, input logic [1:0] a, input logic [7:0] d);
    rnw  = r;
    addr = a;
    din  = d;
    stb  = 1'b1;
    tick();
    stb  = 1'b0;
  endtask

  task automatic expect_ack(input int at, input bit chk, input logic [7:0] d, input string tag);
    exp_t e;
    e.cyc      = at;
    e.chk_data = chk;
    e.data     = d;
    e.tag      = tag;
    exp_q.push_back(e);
  endtask

  task automatic read_expect(input logic [1:0] a, input logic [7:0] d, input string tag);
    expect_ack(cyc + 1, 1'b1, d, tag);
    access(1'b1, a, 8'h00);
    tick();
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d, input string tag);
    expect_ack(cyc + 1, 1'b0, 8'h00, tag);
    access(1'b0, a, d);
    tick();
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {19'h0, busy}, 20'h0);
  endtask

  initial begin
    int t;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_sl1", {12'h0, sl1}, 20'h0);
    check("rst_sl2", {12'h0, sl2}, 20'h0);
    check("rst_cs", {19'h0, snd_cs}, 20'h0);
    check("rst_dtack", {19'h0, dtack}, 20'h0);
    check("rst_dout", {12'h0, dout}, 20'hFF);
    check("rst_busy", {19'h0, busy}, 20'h0);

    // Handshaked write: WAIT falls at t+53, DTACK two cycles later.
    model_en = 1'b1;
    t = cyc;
    expect_ack(t + 1 + 2 + 50 + 2, 1'b0, 8'h00, "hs_write");
    access(1'b0, 2'd0, 8'h5A);
    check("hs_sl1", {12'h0, sl1}, 20'h5A);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("hs_cs_%0d", k), {19'h0, snd_cs}, {19'h0, (k <= 4)});
      tick();
    end
    wait_idle(200, "hs");
    model_en = 1'b0;
    tick();

    // Timed-out write with WAIT stuck low.
    t = cyc;
    expect_ack(t + 106, 1'b0, 8'h00, "to_write");
    access(1'b0, 2'd1, 8'h33);
    check("to_sl2", {12'h0, sl2}, 20'h33);
    wait_idle(200, "to");
    read_expect(2'd2, 8'h04, "to_status");
    write_reg(2'd2, 8'h02, "to_clear");
    read_expect(2'd2, 8'h00, "to_status_clr");

    // Reply flag and read-clear through A=0.
    sl3 = 8'hC1;
    sl4 = 8'h6E;
    sndirq = 1'b1; tick();
    sndirq = 1'b0; tick();
    read_expect(2'd2, 8'h02, "rp_status");
    read_expect(2'd1, 8'h6E, "rp_latch4");
    read_expect(2'd0, 8'hC1, "rp_latch3");
    read_expect(2'd2, 8'h00, "rp_status_clr");
    read_expect(2'd3, 8'hFF, "rp_a3");

    // Set and clear of the reply flag in the same cycle: set wins.
    sndirq = 1'b1; tick();
    sndirq = 1'b0; tick();
    expect_ack(cyc + 1, 1'b0, 8'h00, "sw_clear");
    sndirq = 1'b1;
    access(1'b0, 2'd2, 8'h01);
    sndirq = 1'b0;
    tick();
    read_expect(2'd2, 8'h02, "sw_status");
    write_reg(2'd2, 8'h01, "sw_clear2");
    read_expect(2'd2, 8'h00, "sw_status_clr");

    // A strobe while holding the bus is ignored.
    model_en = 1'b1;
    t = cyc;
    expect_ack(t + 55, 1'b0, 8'h00, "ig_write");
    access(1'b0, 2'd0, 8'h77);
    repeat (8) tick();
    access(1'b0, 2'd0, 8'h11);
    wait_idle(200, "ig");
    check("ig_sl1", {12'h0, sl1}, 20'h77);
    repeat (5) tick();
    model_en = 1'b0;

    // Reset during PULSE aborts the access without a DTACK.
    access(1'b0, 2'd0, 8'h9C);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ar_cs", {19'h0, snd_cs}, 20'h0);
    check("ar_busy", {19'h0, busy}, 20'h0);
    check("ar_sl1", {12'h0, sl1}, 20'h0);
    repeat (120) tick();
    model_en = 1'b1;
    t = cyc;
    expect_ack(t + 55, 1'b0, 8'h00, "ar_write");
    access(1'b0, 2'd1, 8'h42);
    check("ar_sl2", {12'h0, sl2}, 20'h42);
    wait_idle(200, "ar");
    repeat (5) tick();

    check("pending_acks", 20'(exp_q.size()), 20'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/batrider_snd_cmd.md
# batrider_snd_cmd

Main-CPU-side sound command mailbox for the Batrider sound interface. Accepts 68k byte writes to the two command latches, raises the sound-CS edge that sets the Z80 NMI / 68k WAIT flip-flops, and holds the 68k bus cycle until the Z80 clears NMI or a timeout expires. It also serves the Z80 reply latches and a status register back to the 68k. It sits between the 68k bus decoder and the sound block's `CS`/`WAIT`/`SOUNDLATCH*` ports.

## Interface
- `CS_W`, 4: cycles `SND_CS` is held high per command (1..15).
- `TIMEOUT`, 20'd786432: maximum `CLK96` cycles spent in HOLD (8 ms at 96 MHz); width of the timeout counter is 20 bits.

Ports:
- `CLK96`  in  1  system clock; all logic on rising edge.
- `RESET96`  in  1  synchronous, active-high reset.
- `CPU_STB`  in  1  one-cycle pulse marking the start of a 68k access to this block.
- `CPU_RNW`  in  1  1 = read, 0 = write; sampled with `CPU_STB`.
- `CPU_A`  in  2  register select, sampled with `CPU_STB`.
- `CPU_DIN`  in  8  write data (68k low byte), sampled with `CPU_STB`.
- `CPU_DOUT`  out  8  read data; valid while `CPU_DTACK` = 1.
- `CPU_DTACK`  out  1  one-cycle acknowledge ending the access.
- `SOUNDLATCH`  out  8  command latch 1 to the sound side.
- `SOUNDLATCH2`  out  8  command latch 2 to the sound side.
- `SND_CS`  out  1  pulse to the sound side; its rising edge sets NMI/WAIT.
- `SND_WAIT`  in  1  WAIT flag from the sound side; 1 while the Z80 has not cleared NMI.
- `SOUNDLATCH3`  in  8  Z80 reply latch 1.
- `SOUNDLATCH4`  in  8  Z80 reply latch 2.
- `SNDIRQ`  in  1  Z80 reply strobe; a rising edge marks a new reply.
- `BUSY`  out  1  1 whenever the FSM is not in IDLE.

## Operation
- Register map:
  - A=0: write → `SOUNDLATCH`; read → `SOUNDLATCH3`, and the read clears the reply flag.
  - A=1: write → `SOUNDLATCH2`; read → `SOUNDLATCH4`.
  - A=2: read → status `{5'b0, timeout, reply, busy}`; write → if `CPU_DIN[0]`, clear reply; if `CPU_DIN[1]`, clear timeout.
  - A=3: read → 8'hFF; write → no effect.
- FSM states:
  - IDLE: on `CPU_STB` with a write to A=0 or A=1 → latch the byte, go to PULSE. Any other `CPU_STB` → go to ACK.
  - PULSE: `SND_CS`=1 for `CS_W` cycles, then go to HOLD.
  - HOLD: `SND_CS`=0. Leave when `seen_wait` && !`SND_WAIT`, or when the timeout counter reaches `TIMEOUT`-1 (this also sets the timeout flag). Either way, go to ACK.
  - ACK: `CPU_DTACK`=1 for one cycle, then go to IDLE.
- `seen_wait` is cleared on entry to PULSE and set by any cycle with `SND_WAIT`=1 during PULSE or HOLD.
- The timeout counter clears on entry to PULSE and increments every cycle spent in HOLD.
- `CPU_STB` outside IDLE is ignored: no latch update and no extra DTACK.
- Reply flag:
  - Set on a rising edge of `SNDIRQ`, detected with a registered previous value.
  - If a set and a clear occur in the same cycle, the set wins.
- Read data is registered on the IDLE→ACK transition and held through ACK.

## Timing
- Reset values: `SOUNDLATCH`=0, `SOUNDLATCH2`=0, `SND_CS`=0, `CPU_DTACK`=0, `CPU_DOUT`=8'hFF, `BUSY`=0, reply=0, timeout=0, `seen_wait`=0, FSM=IDLE, previous `SNDIRQ`=0.
- Write with a normal handshake, with `CPU_STB` in cycle t:
  - Latch output changes at t+1, and `SND_CS` rises at t+1.
  - `SND_CS` falls at t+1+`CS_W`.
  - `CPU_DTACK` asserts 2 cycles after the first cycle in HOLD that samples `SND_WAIT`=0 with `seen_wait`=1.
- Read latency: `CPU_STB` in cycle t → `CPU_DTACK` and `CPU_DOUT` valid at t+1. Side effects (reply clear, flag clear) take effect at t+1.
- Timed-out write: `CPU_DTACK` asserts at t+1+`CS_W`+`TIMEOUT`+1, and the timeout flag is set one cycle earlier.
- `RESET96` asserted mid-operation: next cycle all outputs hold their reset values and `SND_CS` drops immediately. No DTACK is issued for the aborted access.

## Test plan
- Reset, then write 8'h5A to A=0; the sound model raises `SND_WAIT` 2 cycles after the `SND_CS` edge and drops it 50 cycles later → `SOUNDLATCH`=8'h5A one cycle after the strobe; `SND_CS` high for exactly 4 cycles; exactly one `CPU_DTACK` 2 cycles after `SND_WAIT` falls.
- Write 8'h33 to A=1 with `TIMEOUT`=100 and `SND_WAIT` stuck at 0 → `SOUNDLATCH2`=8'h33; `CPU_DTACK` at t+106; status read returns 8'h04; writing 8'h02 to A=2 clears it, and the next status read returns 8'h00.
- `SOUNDLATCH3`=8'hC1, `SNDIRQ` pulse, then read A=2 then A=0 → status 8'h02, then data 8'hC1 with DTACK at t+1, then status 8'h00.
- `SNDIRQ` rising edge in the same cycle as a status write of 8'h01 → reply remains 1.
- Second `CPU_STB` during HOLD → ignored; `SOUNDLATCH` unchanged, single DTACK.
- `RESET96` asserted for 1 cycle during PULSE → `SND_CS`=0, `BUSY`=0, no DTACK; a following write completes normally.
